alu_flag_stage: RTL and testbench
=================================

Name: alu_flag_stage

Overview:
- Registered output stage directly downstream of the ALU (adder, PADDSB saturating adder, shifter, reduction unit).
- Captures each ALU result and forwards it to the memory/writeback pipeline through a valid/ready handshake with a 2-entry skid buffer.
- Owns the architectural Z/V/N flag register and updates it per opcode when an instruction is accepted.

Parameters:
- DW, 16, data width of result path.
- OPW, 4, opcode width.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  drop all buffered entries and the current input this cycle
- in_valid  input  1  ALU result valid
- in_ready  output  1  stage can accept; registered, depends only on state
- in_opcode  input  OPW  opcode of the instruction producing in_result
- in_result  input  DW  ALU result, already saturated for PADDSB
- in_ovfl  input  1  signed overflow from ADD/SUB adder
- in_psa_err  input  1  PADDSB error, 1+ nibble lanes saturated
- in_wr_en  input  1  instruction writes a register
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream accepts head
- out_opcode  output  OPW  head opcode
- out_result  output  DW  head result
- out_wr_en  output  1  head register-write enable
- flag_z  output  1  zero flag
- flag_v  output  1  overflow flag
- flag_n  output  1  negative flag
- sat_cnt  output  16  PADDSB saturation event count; present only with ALU_SAT_CNT_EN

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0; both entries invalid; in_ready=1.
  - flag_z=flag_v=flag_n=0; sat_cnt=0.
  - out_opcode, out_result and out_wr_en are 0.
- Accept = in_valid & in_ready & ~flush. Pop = out_valid & out_ready.
- Latency: an accepted entry appears at the outputs the next cycle when the head is empty, or when the head is popping that cycle.
- Buffer: head register plus skid register.
  - Accept with head free (empty or popping): entry goes to head.
  - Accept with head held: entry goes to skid.
  - Pop with skid valid: skid moves to head.
  - Accept and pop together with skid valid is impossible because in_ready=0 then.
- in_ready = ~skid_valid, taken from a flop with no combinational path from out_ready.
- Ordering is strictly FIFO. out_* hold stable while out_valid & ~out_ready.
- Flush:
  - Next cycle both entries are invalid, out_valid=0 and in_ready=1.
  - The input presented in the flush cycle is not accepted and does not touch the flags.
  - A pop that happens in the flush cycle still counts as completed downstream.
- Flag update happens only on Accept and is visible the cycle after. Opcode rules:
  - 0000 ADD, 0001 SUB: Z=(in_result==0), V=in_ovfl, N=in_result[DW-1].
  - 0010 XOR, 0100 SLL, 0101 SRA, 0110 ROR: Z updated; V and N held.
  - 0011 RED, 0111 PADDSB and all others: flags held.
- Flags are never restored by flush; they reflect accepted instructions only.
- No illegal states: an invalid head with a valid skid never occurs.
  - If skid_valid & ~head_valid is reached, the next cycle returns to the empty state.
- Reset asserted mid-transfer drops all entries immediately; deasserting reset has no effect until the next rising clk edge.

Optional Feature:
- Macro: ALU_SAT_CNT_EN.
- Defined: sat_cnt port exists.
  - Increments by 1 on every Accept with opcode 0111 and in_psa_err=1.
  - Saturates at 16'hFFFF (no wrap).
  - Cleared only by reset, not by flush.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams: OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_SLL, OP_SRA, OP_ROR, OP_PADDSB.
  - Packed typedef flags_t {z,v,n}.
  - Packed typedef alu_entry_t {opcode, result, wr_en}.
- One sub-module: alu_skid_buf. It is a generic 2-entry valid/ready skid buffer of alu_entry_t with flush.
- Flag logic and the counter stay in alu_flag_stage.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 and in_result=16'h1234 -> out_valid=0, in_ready=1, flags 000, sat_cnt=0 throughout.
- ADD 16'h7FFF+1 (result 16'h8000, ovfl=1) accepted -> next cycle Z=0, V=1, N=1; out_result=16'h8000 after one cycle.
- Backpressure: out_ready=0, three back-to-back valid inputs A, B, C -> A at head, B in skid, in_ready=0, C held. Then out_ready=1 -> A, B, C emerge in order with no loss or duplication.
- XOR result 0 after an ADD that set V=1, N=1 -> Z=1, V=1, N=1 (V and N held). Then PADDSB with result 16'h0000 -> flags unchanged.
- Flush with both entries full and in_valid=1 (SUB result 0) -> next cycle out_valid=0, in_ready=1, flags unchanged.
- ALU_SAT_CNT_EN defined:
  - 5 PADDSB accepts with psa_err=1 and 2 with psa_err=0 -> sat_cnt=5.
  - Preload near max and apply 2 more error accepts -> sat_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//
// Shared definitions for the ALU output stage:
//   - default data/opcode widths
//   - opcode encodings
//   - flags_t     : architectural Z/V/N flag word
//   - alu_entry_t : one ALU result as it travels to memory/writeback
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_DW    = 16;
    localparam int ALU_OPW   = 4;
    localparam int SAT_CNT_W = 16;

    localparam logic [ALU_OPW-1:0] OP_ADD    = 4'b0000;
    localparam logic [ALU_OPW-1:0] OP_SUB    = 4'b0001;
    localparam logic [ALU_OPW-1:0] OP_XOR    = 4'b0010;
    localparam logic [ALU_OPW-1:0] OP_RED    = 4'b0011;
    localparam logic [ALU_OPW-1:0] OP_SLL    = 4'b0100;
    localparam logic [ALU_OPW-1:0] OP_SRA    = 4'b0101;
    localparam logic [ALU_OPW-1:0] OP_ROR    = 4'b0110;
    localparam logic [ALU_OPW-1:0] OP_PADDSB = 4'b0111;

    typedef struct packed {
        logic z;
        logic v;
        logic n;
    } flags_t;

    typedef struct packed {
        logic [ALU_OPW-1:0] opcode;
        logic [ALU_DW-1:0]  result;
        logic               wr_en;
    } alu_entry_t;

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [SAT_CNT_W-1:0] sat_inc(input logic [SAT_CNT_W-1:0] cnt);
        return (cnt == '1) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// ---------------------------------------------------------------------------
// alu_skid_buf
//
// Generic 2-entry valid/ready skid buffer (head + skid register) with flush.
// in_ready comes straight from a flop (= ~skid_valid), so there is no
// combinational path from out_ready to in_ready.
//
// Parameters:
//   T          payload type (defaults to alu_entry_t)
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 drop both entries and refuse the current input
//   in_valid/in_ready     upstream handshake
//   in_data               upstream payload
//   accept                in_valid & in_ready & ~flush (for side effects)
//   out_valid/out_ready   downstream handshake
//   out_data              head payload, stable while stalled
// ---------------------------------------------------------------------------
module alu_skid_buf
    import alu_pkg::*;
#(
    parameter type T = alu_entry_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic accept,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    logic head_valid;
    logic skid_valid;
    logic in_ready_q;
    T     head_q;
    T     skid_q;

    logic head_valid_d;
    logic skid_valid_d;
    logic load_head_from_in;
    logic load_head_from_skid;
    logic load_skid;
    logic pop;

    assign accept = in_valid & in_ready_q & ~flush;
    assign pop    = head_valid & out_ready;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        head_valid_d        = head_valid;
        skid_valid_d        = skid_valid;
        load_head_from_in   = 1'b0;
        load_head_from_skid = 1'b0;
        load_skid           = 1'b0;

        if (flush || (skid_valid && !head_valid)) begin
            // Flush, or recovery from the unreachable skid-without-head state.
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (pop && skid_valid) begin
            // in_ready is low whenever skid is valid, so no accept can coincide.
            load_head_from_skid = 1'b1;
            head_valid_d        = 1'b1;
            skid_valid_d        = 1'b0;
        end else if (accept && (!head_valid || pop)) begin
            load_head_from_in = 1'b1;
            head_valid_d      = 1'b1;
        end else if (accept) begin
            load_skid    = 1'b1;
            skid_valid_d = 1'b1;
        end else if (pop) begin
            head_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            head_valid <= head_valid_d;
            skid_valid <= skid_valid_d;
            in_ready_q <= ~skid_valid_d;
        end
    end

    // NOTE: payload registers are reset too because the head fields are visible outputs that must read 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_head_from_skid) begin
                head_q <= skid_q;
            end else if (load_head_from_in) begin
                head_q <= in_data;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = head_valid;
    assign out_data  = head_q;

endmodule

// File: rtl/alu_flag_stage.sv
// ---------------------------------------------------------------------------
// alu_flag_stage
//
// Registered output stage behind the ALU. Forwards each ALU result to the
// memory/writeback pipeline through a 2-entry skid buffer and owns the
// architectural Z/V/N flag register, updated on every accepted instruction.
//
// Optional feature: define ALU_SAT_CNT_EN to add the sat_cnt port, a
// saturating count of accepted PADDSB instructions that reported a lane
// saturation.
//
// Parameters: DW (result width), OPW (opcode width)
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   flush                           drop buffered entries and current input
//   in_valid/in_ready               ALU-side handshake (in_ready registered)
//   in_opcode/in_result/in_ovfl     ALU result, opcode, adder overflow
//   in_psa_err/in_wr_en             PADDSB saturation, register write enable
//   out_valid/out_ready             writeback-side handshake
//   out_opcode/out_result/out_wr_en head entry
//   flag_z/flag_v/flag_n            architectural flags
//   sat_cnt                         PADDSB saturation count (ALU_SAT_CNT_EN)
// ---------------------------------------------------------------------------
module alu_flag_stage
    import alu_pkg::*;
#(
    parameter int DW  = ALU_DW,
    parameter int OPW = ALU_OPW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] in_opcode,
    input  logic [DW-1:0]  in_result,
    input  logic           in_ovfl,
    input  logic           in_psa_err,
    input  logic           in_wr_en,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OPW-1:0] out_opcode,
    output logic [DW-1:0]  out_result,
    output logic           out_wr_en,
    output logic           flag_z,
    output logic           flag_v,
    output logic           flag_n
`ifdef ALU_SAT_CNT_EN
    ,
    output logic [SAT_CNT_W-1:0] sat_cnt
`endif
);

    // Same layout as alu_entry_t, but sized by this instance's parameters.
    typedef struct packed {
        logic [OPW-1:0] opcode;
        logic [DW-1:0]  result;
        logic           wr_en;
    } entry_t;

    entry_t in_entry;
    entry_t head_entry;
    logic   accept;

    assign in_entry = '{opcode: in_opcode, result: in_result, wr_en: in_wr_en};

    alu_skid_buf #(
        .T (entry_t)
    ) u_skid_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .accept    (accept),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head_entry)
    );

    assign out_opcode = head_entry.opcode;
    assign out_result = head_entry.result;
    assign out_wr_en  = head_entry.wr_en;

    // ------------------------------------------------------------------
    // Flags: only accepted instructions update them; flush never restores.
    // ------------------------------------------------------------------
    flags_t flags_q;
    flags_t flags_d;
    logic   result_zero;

    assign result_zero = (in_result == '0);

    always_comb begin
        flags_d = flags_q;
        if (accept) begin
            unique case (in_opcode)
                OPW'(OP_ADD), OPW'(OP_SUB): begin
                    flags_d.z = result_zero;
                    flags_d.v = in_ovfl;
                    flags_d.n = in_result[DW-1];
                end
                OPW'(OP_XOR), OPW'(OP_SLL), OPW'(OP_SRA), OPW'(OP_ROR): begin
                    flags_d.z = result_zero;
                end
                default: begin
                    // RED, PADDSB and unassigned opcodes leave flags alone.
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flag_z = flags_q.z;
    assign flag_v = flags_q.v;
    assign flag_n = flags_q.n;

`ifdef ALU_SAT_CNT_EN
    // ------------------------------------------------------------------
    // PADDSB saturation event counter; cleared by reset only.
    // ------------------------------------------------------------------
    logic [SAT_CNT_W-1:0] sat_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_q <= '0;
        end else if (accept && in_psa_err && (in_opcode == OPW'(OP_PADDSB))) begin
            sat_cnt_q <= sat_inc(sat_cnt_q);
        end
    end

    assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_alu_flag_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_flag_stage
//
// Directed bench for alu_flag_stage. Inputs are driven 1 time unit after the
// rising edge and outputs are observed at that same point, i.e. they show
// the state produced by the preceding edge. Expected values are hand-derived.
// Define ALU_SAT_CNT_EN to also exercise the saturation counter.
// ---------------------------------------------------------------------------
module tb_alu_flag_stage;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [15:0] in_result;
    logic        in_ovfl;
    logic        in_psa_err;
    logic        in_wr_en;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_opcode;
    logic [15:0] out_result;
    logic        out_wr_en;
    logic        flag_z;
    logic        flag_v;
    logic        flag_n;
`ifdef ALU_SAT_CNT_EN
    logic [15:0] sat_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    alu_flag_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_result  (in_result),
        .in_ovfl    (in_ovfl),
        .in_psa_err (in_psa_err),
        .in_wr_en   (in_wr_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_opcode (out_opcode),
        .out_result (out_result),
        .out_wr_en  (out_wr_en),
        .flag_z     (flag_z),
        .flag_v     (flag_v),
        .flag_n     (flag_n)
`ifdef ALU_SAT_CNT_EN
        ,
        .sat_cnt    (sat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic [3:0] op, input logic [15:0] res,
                         input logic ovfl, input logic psa, input logic wr);
        in_valid   = valid;
        in_opcode  = op;
        in_result  = res;
        in_ovfl    = ovfl;
        in_psa_err = psa;
        in_wr_en   = wr;
    endtask

    function automatic logic [31:0] flags3();
        return {29'd0, flag_z, flag_v, flag_n};
    endfunction

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, OP_ADD, 16'h1234, 1'b0, 1'b0, 1'b1);

        // ---------------- reset held with a valid input present ----------
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_in_ready", {31'd0, in_ready}, 32'd1);
            check("rst_flags", flags3(), 32'd0);
        end
        check("rst_out_result", {16'd0, out_result}, 32'd0);
        check("rst_out_opcode", {28'd0, out_opcode}, 32'd0);
        check("rst_out_wr_en", {31'd0, out_wr_en}, 32'd0);
`ifdef ALU_SAT_CNT_EN
        check("rst_sat_cnt", {16'd0, sat_cnt}, 32'd0);
`endif
        drive(1'b0, OP_ADD, 16'h0000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

        // ---------------- ADD 7FFF+1 -> 8000 with overflow ---------------
        drive(1'b1, OP_ADD, 16'h8000, 1'b1, 1'b0, 1'b1);
        step();
        check("add_out_valid", {31'd0, out_valid}, 32'd1);
        check("add_out_result", {16'd0, out_result}, 32'h8000);
        check("add_out_opcode", {28'd0, out_opcode}, 32'(OP_ADD));
        check("add_out_wr_en", {31'd0, out_wr_en}, 32'd1);
        check("add_flags", flags3(), 32'b011);
        drive(1'b0, OP_ADD, 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        check("add_popped", {31'd0, out_valid}, 32'd0);

        // ---------------- per-opcode flag rules --------------------------
        drive(1'b1, OP_XOR, 16'h0000, 1'b0, 1'b0, 1'b1);
        step();
        check("xor_zero_flags", flags3(), 32'b111);
        drive(1'b1, OP_PADDSB, 16'h0000, 1'b0, 1'b0, 1'b1);
        step();
        check("paddsb_flags_held", flags3(), 32'b111);
        check("paddsb_out_opcode", {28'd0, out_opcode}, 32'(OP_PADDSB));
        drive(1'b1, OP_SLL, 16'h0001, 1'b1, 1'b0, 1'b1);
        step();
        check("sll_flags", flags3(), 32'b011);
        drive(1'b1, OP_SUB, 16'h0001, 1'b0, 1'b0, 1'b1);
        step();
        check("sub_flags", flags3(), 32'b000);
        drive(1'b1, OP_ROR, 16'h0000, 1'b1, 1'b0, 1'b0);
        step();
        check("ror_flags", flags3(), 32'b100);
        check("ror_out_wr_en", {31'd0, out_wr_en}, 32'd0);
        drive(1'b1, OP_RED, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        step();
        check("red_flags_held", flags3(), 32'b100);
        drive(1'b0, OP_ADD, 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        check("drain_empty", {31'd0, out_valid}, 32'd0);

        // ---------------- backpressure: A, B, C in FIFO order ------------
        out_ready = 1'b0;
        drive(1'b1, OP_RED, 16'hAAAA, 1'b0, 1'b0, 1'b1);
        step();
        check("bp_a_head", {16'd0, out_result}, 32'hAAAA);
        check("bp_a_in_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b1, OP_RED, 16'hBBBB, 1'b0, 1'b0, 1'b0);
        step();
        check("bp_b_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_b_head_still_a", {16'd0, out_result}, 32'hAAAA);
        drive(1'b1, OP_RED, 16'hCCCC, 1'b0, 1'b0, 1'b1);
        step();
        check("bp_c_held_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_c_head_stable", {16'd0, out_result}, 32'hAAAA);
        check("bp_c_wr_en_stable", {31'd0, out_wr_en}, 32'd1);
        out_ready = 1'b1;
        step();
        check("bp_pop_b", {16'd0, out_result}, 32'hBBBB);
        check("bp_pop_b_wr_en", {31'd0, out_wr_en}, 32'd0);
        check("bp_ready_again", {31'd0, in_ready}, 32'd1);
        step();
        check("bp_pop_c", {16'd0, out_result}, 32'hCCCC);
        check("bp_pop_c_valid", {31'd0, out_valid}, 32'd1);
        drive(1'b0, OP_ADD, 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        check("bp_no_dup", {31'd0, out_valid}, 32'd0);
        check("bp_flags_held", flags3(), 32'b100);

        // ---------------- flush with both entries full -------------------
        out_ready = 1'b0;
        drive(1'b1, OP_RED, 16'h1111, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b1, OP_RED, 16'h2222, 1'b0, 1'b0, 1'b1);
        step();
        check("fl_full_in_ready", {31'd0, in_ready}, 32'd0);
        flush = 1'b1;
        drive(1'b1, OP_SUB, 16'h0000, 1'b1, 1'b0, 1'b1);
        step();
        flush = 1'b0;
        drive(1'b0, OP_ADD, 16'h0000, 1'b0, 1'b0, 1'b0);
        check("fl_out_valid", {31'd0, out_valid}, 32'd0);
        check("fl_in_ready", {31'd0, in_ready}, 32'd1);
        check("fl_flags_held", flags3(), 32'b100);

        // ---------------- flush with empty buffer and a flag-changing op -
        flush = 1'b1;
        drive(1'b1, OP_SUB, 16'h8000, 1'b1, 1'b0, 1'b1);
        step();
        flush = 1'b0;
        drive(1'b0, OP_ADD, 16'h0000, 1'b0, 1'b0, 1'b0);
        check("fl2_not_accepted", {31'd0, out_valid}, 32'd0);
        check("fl2_flags_held", flags3(), 32'b100);
        out_ready = 1'b1;

`ifdef ALU_SAT_CNT_EN
        // ---------------- saturation counter -----------------------------
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, OP_PADDSB, 16'h7F7F, 1'b0, (i != 2 && i != 5), 1'b1);
            step();
        end
        // A non-PADDSB op with psa_err set must not count.
        drive(1'b1, OP_ADD, 16'h0001, 1'b0, 1'b1, 1'b1);
        step();
        drive(1'b0, OP_ADD, 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        check("sat_cnt_five", {16'd0, sat_cnt}, 32'd5);
        // Flush with a PADDSB error on the input does not count and does not clear.
        flush = 1'b1;
        drive(1'b1, OP_PADDSB, 16'h7F7F, 1'b0, 1'b1, 1'b1);
        step();
        flush = 1'b0;
        check("sat_cnt_flush", {16'd0, sat_cnt}, 32'd5);
        force dut.sat_cnt_q = 16'hFFFE;
        #2;
        release dut.sat_cnt_q;
        drive(1'b1, OP_PADDSB, 16'h7F7F, 1'b0, 1'b1, 1'b1);
        step();
        check("sat_cnt_max", {16'd0, sat_cnt}, 32'hFFFF);
        step();
        check("sat_cnt_hold", {16'd0, sat_cnt}, 32'hFFFF);
        drive(1'b0, OP_ADD, 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
`endif

        // ---------------- asynchronous reset mid-transfer ----------------
        out_ready = 1'b0;
        drive(1'b1, OP_ADD, 16'h8000, 1'b1, 1'b0, 1'b1);
        step();
        check("ar_loaded", {31'd0, out_valid}, 32'd1);
        drive(1'b1, OP_RED, 16'h5555, 1'b0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", {31'd0, out_valid}, 32'd0);
        check("ar_in_ready", {31'd0, in_ready}, 32'd1);
        check("ar_flags", flags3(), 32'd0);
        check("ar_out_result", {16'd0, out_result}, 32'd0);
        #4;
        rst_n = 1'b1;
        step();
        check("ar_resume", {16'd0, out_result}, 32'h5555);
        check("ar_resume_valid", {31'd0, out_valid}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
